// File: rtl/dct_arb_pkg.sv
// Shared types and the round-robin pick helper for the DCT block arbiter.
package dct_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam int BLK_SAMPLES = 64;
  localparam int MAX_REQ     = 8;

  // First set bit after ptr, wrapping modulo n_req; returns ptr if nothing is valid.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 n_req);
    logic [2:0] pick;
    int         idx;
    pick = ptr;
    // Walk farthest-first so the nearest valid requester is the last one written.
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n_req) begin
        idx = (int'(ptr) + i) % n_req;
        if (valid[idx[2:0]]) pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: valid vector and last-owner pointer in, grant ID out.
module rr_arbiter
  import dct_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  grant,
  output logic             any_valid
);

  assign grant     = ID_W'(rr_pick(MAX_REQ'(valid), 3'(ptr), N_REQ));
  assign any_valid = |valid;

endmodule

// File: rtl/dct_block_arbiter.sv
// Shares one whole-block 8x8 DCT core between N_REQ producers, one block in flight.
// Optional watchdog on the core response is enabled by defining DCT_ARB_WDOG_EN.
module dct_block_arbiter
  import dct_arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int IN_W     = 32,
  parameter int WDOG_CYC = 64,
  localparam int ID_W    = $clog2(N_REQ),
  localparam int BLK_W   = BLK_SAMPLES * IN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*BLK_W-1:0] req_block,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   core_in_valid,
  output logic [BLK_W-1:0]       core_in_block,
  input  logic                   core_in_ready,
  input  logic                   core_out_valid,
  input  logic [BLK_W-1:0]       core_out_block,
  output logic                   core_out_ready,
  output logic                   rsp_valid,
  output logic [BLK_W-1:0]       rsp_block,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy,
  output logic                   err_timeout
);

  // state   | meaning
  // S_IDLE  | no block in flight, arbitrating among req_valid
  // S_ISSUE | presenting owner's block to the core until accepted
  // S_WAIT  | waiting for the core result and forwarding it downstream

  state_t          state;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .valid    (req_valid),
    .ptr      (rr_ptr),
    .grant    (pick_id),
    .any_valid(pick_any)
  );

`ifdef DCT_ARB_WDOG_EN
  localparam int WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_fire;

  assign wdog_fire = (state == S_WAIT) && !core_out_valid &&
                     (wdog_cnt == WDOG_W'(WDOG_CYC - 1));
`else
  // Constant 0 for any legal WDOG_CYC when the watchdog is not built.
  assign err_timeout = (WDOG_CYC < 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      owner  <= '0;
      rr_ptr <= ID_W'(N_REQ - 1);
`ifdef DCT_ARB_WDOG_EN
      wdog_cnt    <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
`ifdef DCT_ARB_WDOG_EN
      err_timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            owner <= pick_id;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (core_in_ready) begin
            state <= S_WAIT;
`ifdef DCT_ARB_WDOG_EN
            wdog_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (core_out_valid && rsp_ready) begin
            rr_ptr <= owner;
            state  <= S_IDLE;
          end
`ifdef DCT_ARB_WDOG_EN
          else if (wdog_fire) begin
            err_timeout <= 1'b1;
            rr_ptr      <= owner;
            state       <= S_IDLE;
          end else if (!core_out_valid) begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready      = '0;
    core_in_valid  = 1'b0;
    core_in_block  = '0;
    core_out_ready = 1'b0;
    rsp_valid      = 1'b0;
    rsp_block      = '0;
    rsp_id         = '0;
    case (state)
      S_ISSUE: begin
        core_in_valid    = 1'b1;
        core_in_block    = req_block[int'(owner)*BLK_W +: BLK_W];
        req_ready[owner] = core_in_ready;
      end
      S_WAIT: begin
        rsp_valid      = core_out_valid;
        rsp_block      = core_out_block;
        rsp_id         = owner;
        core_out_ready = rsp_ready;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_dct_block_arbiter.sv
// Directed bench for dct_block_arbiter with a fixed-latency core stub and a grant/response scoreboard.
module tb_dct_block_arbiter;

  localparam int N    = 3;
  localparam int IN_W = 32;
  localparam int BW   = 64 * IN_W;
  localparam int LAT  = 16;
  localparam int WDOG = 8;

  typedef logic [BW-1:0] blk_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*BW-1:0] req_block;
  logic [N-1:0]   req_ready;
  logic           core_in_valid;
  blk_t           core_in_block;
  logic           core_in_ready;
  logic           core_out_valid;
  blk_t           core_out_block;
  logic           core_out_ready;
  logic           rsp_valid;
  blk_t           rsp_block;
  logic [1:0]     rsp_id;
  logic           rsp_ready;
  logic           busy;
  logic           err_timeout;

  dct_block_arbiter #(.N_REQ(N), .IN_W(IN_W), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_block(req_block), .req_ready(req_ready),
    .core_in_valid(core_in_valid), .core_in_block(core_in_block), .core_in_ready(core_in_ready),
    .core_out_valid(core_out_valid), .core_out_block(core_out_block), .core_out_ready(core_out_ready),
    .rsp_valid(rsp_valid), .rsp_block(rsp_block), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_blk(string name, blk_t act, blk_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < 64; i++) begin
        if (act[i*IN_W +: IN_W] !== exp[i*IN_W +: IN_W]) begin
          $display("FAIL %s: sample %0d got %0h expected %0h", name, i,
                   act[i*IN_W +: IN_W], exp[i*IN_W +: IN_W]);
          break;
        end
      end
    end
  endtask

  // Requester r's n-th block; requester 1's first block is a flat field of 10.0 (x256).
  function automatic blk_t blk_data(int r, int n);
    blk_t b;
    for (int i = 0; i < 64; i++) begin
      if (r == 1 && n == 0) b[i*IN_W +: IN_W] = 32'd2560;
      else b[i*IN_W +: IN_W] = 32'(r * 100000 + n * 1000 + i * (r + 3) - 5000);
    end
    return b;
  endfunction

  // Core stand-in: DC = sum/8 (orthonormal 2-D DCT), other terms = sample minus sample 0.
  function automatic blk_t golden(blk_t b);
    blk_t              o;
    logic signed [31:0] t;
    int                s;
    s = 0;
    for (int i = 0; i < 64; i++) begin
      t = b[i*IN_W +: IN_W];
      s += int'(t);
    end
    o[0 +: IN_W] = 32'(s >>> 3);
    for (int i = 1; i < 64; i++) o[i*IN_W +: IN_W] = b[i*IN_W +: IN_W] - b[0 +: IN_W];
    return o;
  endfunction

  function automatic int model_pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Core stub
  logic stub_full;
  logic stub_never;
  int   stub_cnt;
  blk_t stub_data;

  assign core_in_ready  = !stub_full;
  assign core_out_valid = stub_full && (stub_cnt == 0);
  assign core_out_block = stub_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_full <= 1'b0;
      stub_cnt  <= 0;
      stub_data <= '0;
    end else begin
      if (core_out_valid && core_out_ready) stub_full <= 1'b0;
      else if (stub_full && stub_cnt > 0) stub_cnt <= stub_cnt - 1;
      if (core_in_valid && core_in_ready && !stub_never) begin
        stub_full <= 1'b1;
        stub_cnt  <= LAT - 1;
        stub_data <= golden(core_in_block);
      end
    end
  end

  // Requesters: reload or drop after each accepted block
  logic [N-1:0] acc_q = '0;
  int remaining[N];
  int blk_num[N];

  task automatic post(int r, int cnt);
    remaining[r] = cnt;
    req_block[r*BW +: BW] = blk_data(r, blk_num[r]);
    req_valid[r] = 1'b1;
  endtask

  always @(negedge clk) if (rst_n) acc_q = acc_q | (req_valid & req_ready);

  always @(posedge clk) begin
    #1;
    for (int r = 0; r < N; r++) begin
      if (acc_q[r]) begin
        blk_num[r]++;
        remaining[r]--;
        if (remaining[r] > 0) req_block[r*BW +: BW] = blk_data(r, blk_num[r]);
        else req_valid[r] = 1'b0;
      end
    end
    acc_q = '0;
  end

  // Scoreboard and compare process
  int   cyc = 0;
  int   model_last = N - 1;
  int   exp_id[$];
  blk_t exp_blk[$];
  int   rsp_log[$];
  int   rsp_cnt = 0;
  blk_t last_rsp;
  int   err_cnt = 0;
  int   issue_cyc = 0;
  int   err_delta[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (|req_ready) begin
        int g;
        g = -1;
        for (int r = N - 1; r >= 0; r--) if (req_ready[r]) g = r;
        check("grant_onehot", $countones(req_ready), 1);
        check("grant_order", g, model_pick(req_valid, model_last));
        check("grant_core_valid", core_in_valid, 1);
        check_blk("issue_block", core_in_block, blk_data(g, blk_num[g]));
        exp_id.push_back(g);
        exp_blk.push_back(golden(blk_data(g, blk_num[g])));
        issue_cyc = cyc;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_id.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          check("rsp_id", rsp_id, exp_id[0]);
          check_blk("rsp_block", rsp_block, exp_blk[0]);
          model_last = exp_id.pop_front();
          void'(exp_blk.pop_front());
        end
        rsp_log.push_back(int'(rsp_id));
        last_rsp = rsp_block;
        rsp_cnt++;
      end
      if (err_timeout) begin
        err_cnt++;
        err_delta.push_back(cyc - issue_cyc);
        if (exp_id.size() > 0) begin
          model_last = exp_id.pop_front();
          void'(exp_blk.pop_front());
        end
      end
    end
  end

  task automatic clear_model();
    exp_id.delete();
    exp_blk.delete();
    model_last = N - 1;
  endtask

  task automatic wait_rsp(int target, int budget, string name);
    int k;
    k = 0;
    while (rsp_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, rsp_cnt >= target, 1);
    #1;
  endtask

  task automatic wait_in_wait(string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!(busy && !core_in_valid) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, busy && !core_in_valid, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    for (int r = 0; r < N; r++) remaining[r] = 0;
    repeat (2) @(posedge clk);
    clear_model();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int   base;
    int   seq6[6];
    int   hold_id;
    blk_t hold_blk;

    rst_n = 1'b0;
    req_valid = '0;
    req_block = '0;
    rsp_ready = 1'b1;
    stub_never = 1'b0;
    for (int r = 0; r < N; r++) begin
      remaining[r] = 0;
      blk_num[r] = 0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_core_in_valid", core_in_valid, 0);
    check("rst_core_out_ready", core_out_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_err_timeout", err_timeout, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester, flat block
    @(posedge clk);
    #1 post(1, 1);
    @(negedge clk) check("ready_not_same_cycle", req_ready, 3'b000);
    @(negedge clk) check("ready_next_cycle", req_ready, 3'b010);
    wait_rsp(1, 60, "single_done");
    check("single_id", rsp_log[rsp_log.size()-1], 1);
    check("single_dc", last_rsp[0 +: IN_W], 32'd20480);
    check("single_ac_zero", (last_rsp[BW-1:IN_W] == '0), 1);

    // Reset while the block sits in the core
    @(posedge clk);
    #1 post(0, 1);
    wait_in_wait("mid_reset_reach_wait");
    repeat (3) @(posedge clk);
    base = rsp_cnt;
    #3 rst_n = 1'b0;
    #1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_rsp_valid", rsp_valid, 0);
    check("mid_reset_core_in_valid", core_in_valid, 0);
    clear_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    check("mid_reset_no_rsp", rsp_cnt, base);
    #1 post(0, 1);
    wait_rsp(base + 1, 60, "after_reset_done");
    check("after_reset_id", rsp_log[rsp_log.size()-1], 0);

    // Full contention: six blocks rotate 0,1,2,0,1,2
    do_reset();
    base = rsp_cnt;
    post(0, 2);
    post(1, 2);
    post(2, 2);
    wait_rsp(base + 6, 200, "contention_done");
    seq6 = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 6; i++) check($sformatf("contention_id%0d", i), rsp_log[base + i], seq6[i]);

    // Back-pressure hold for 20 cycles
    base = rsp_cnt;
    rsp_ready = 1'b0;
    post(0, 1);
    begin
      int k;
      k = 0;
      @(negedge clk);
      while (!rsp_valid && k < 60) begin
        @(negedge clk);
        k++;
      end
    end
    check("bp_rsp_valid", rsp_valid, 1);
    hold_id = int'(rsp_id);
    hold_blk = rsp_block;
    check("bp_hold_id", hold_id, 0);
    @(posedge clk);
    #1 post(1, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid_stable", rsp_valid, 1);
      check("bp_id_stable", rsp_id, hold_id);
      check_blk("bp_block_stable", rsp_block, hold_blk);
      check("bp_no_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    check("bp_one_rsp", rsp_cnt, base + 1);
    wait_rsp(base + 2, 60, "bp_next_done");
    check("bp_next_id", rsp_log[base + 1], 1);

    // Late arrival while owner 0 waits on the core
    base = rsp_cnt;
    @(posedge clk);
    #1 post(0, 1);
    wait_in_wait("late_a_reach_wait");
    @(posedge clk);
    #1 post(2, 1);
    wait_rsp(base + 2, 100, "late_a_done");
    check("late_a_first", rsp_log[base], 0);
    check("late_a_second", rsp_log[base + 1], 2);

    base = rsp_cnt;
    @(posedge clk);
    #1 post(0, 1);
    wait_in_wait("late_b_reach_wait");
    @(posedge clk);
    #1;
    post(2, 1);
    post(1, 1);
    wait_rsp(base + 3, 120, "late_b_done");
    check("late_b_first", rsp_log[base], 0);
    check("late_b_second", rsp_log[base + 1], 1);
    check("late_b_third", rsp_log[base + 2], 2);

`ifdef DCT_ARB_WDOG_EN
    // Core never answers: each grant times out 8 cycles after entering S_WAIT
    base = rsp_cnt;
    @(posedge clk);
    #1;
    stub_never = 1'b1;
    post(0, 1);
    post(1, 1);
    begin
      int k;
      k = 0;
      while (err_cnt < 2 && k < 80) begin
        @(posedge clk);
        k++;
      end
    end
    check("wdog_pulses", err_cnt, 2);
    if (err_delta.size() >= 2) begin
      check("wdog_delay0", err_delta[0], 9);
      check("wdog_delay1", err_delta[1], 9);
    end
    check("wdog_no_rsp", rsp_cnt, base);
    check("wdog_next_grant", model_last, 1);
    stub_never = 1'b0;
`else
    check("err_timeout_tied", err_cnt, 0);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
